quad_encoder_counter: RTL and testbench
=======================================

// Module: quad_encoder_counter
// PURPOSE
//   Parametrised quadrature encoder front-end for the motor path: synchronises and
//   deglitches A/B, decodes x4 steps with selectable polarity, and keeps a signed
//   position counter. Also measures the step period for speed estimation and flags
//   illegal transitions. Feeds the motor control / speed loop.
// PARAMETERS
//   SYNC_STAGES   2   flip-flop synchroniser depth on i_a/i_b (>=2)
//   FILTER_LEN    4   consecutive identical samples before a filtered level changes (>=1)
//   POS_WIDTH     32  position counter width, two's complement
//   PERIOD_WIDTH  20  step-period counter width, in i_clk cycles
// PORTS
//   i_clk           in   1             master clock
//   i_rst           in   1             asynchronous, active-high reset
//   i_a             in   1             encoder A, asynchronous to i_clk
//   i_b             in   1             encoder B, asynchronous to i_clk
//   i_polarity      in   1             0: forward sequence counts up; 1: inverted
//   i_clear         in   1             sync clear of position, error flag and period counter
//   i_load          in   1             sync load of position from i_load_val
//   i_load_val      in   POS_WIDTH     position preload value
//   o_step          out  1             one-cycle pulse per decoded step
//   o_dir           out  1             direction of last step (1 = up), held between steps
//   o_dir_change    out  1             one-cycle pulse with o_step when o_dir flips
//   o_position      out  POS_WIDTH     signed position
//   o_period        out  PERIOD_WIDTH  cycles between the last two steps
//   o_period_valid  out  1             one-cycle pulse when o_period updates
//   o_stalled       out  1             period counter saturated, no step seen
//   o_err           out  1             sticky: illegal double transition seen
// BEHAVIOUR
//   - Reset: every output is 0. Sync chain and filter state are 00. prev_ab = 00.
//   - Sync: i_a and i_b each pass through a SYNC_STAGES chain. No other logic samples the raw inputs.
//   - Filter: one counter per channel. It reloads whenever the synced level equals the filtered
//     level. The filtered level takes the synced level after FILTER_LEN consecutive differing
//     samples. Pulses shorter than FILTER_LEN cycles never reach the decoder.
//   - Decode: compare filtered ab with registered prev_ab every cycle; prev_ab <= ab.
//     Forward sequence: 00->10->11->01->00. Reverse is the opposite order.
//     up = forward XOR i_polarity.
//   - Latency: edge on i_a -> o_step is exactly SYNC_STAGES+FILTER_LEN+1 cycles.
//   - Both bits change in one cycle: set o_err (sticky), no step, no position change.
//     prev_ab still updates, so decoding resyncs.
//   - Step: o_step=1, o_dir=up, o_dir_change = (up != o_dir). No dir_change on the first step after reset/clear.
//   - Position: +1/-1 per step, modulo 2^POS_WIDTH. Wraps max->min with no flag.
//   - Priority, same cycle: i_clear > i_load > step. A step coinciding with clear or load is dropped.
//     Clear: position=0, o_err=0, period counter=0, o_stalled=0.
//   - Period: counter increments each cycle, saturating at 2^PERIOD_WIDTH-1. Saturated -> o_stalled=1.
//     On a step: o_period <= counter+1 (saturated value if stalled). Then counter=0, o_stalled=0,
//     and o_period_valid pulses.
//     The first step after reset/clear updates o_period but does not pulse o_period_valid.
//   - Reset asserted mid-operation: immediate return to the reset state. No residual pulses after release.
// STRUCTURE
//   - Package encoder_pkg: typedef enum ab_t {AB_00,AB_01,AB_10,AB_11}; a function
//     next_fwd(ab_t) implementing the forward Gray table; localparam for the period saturation value.
//   - Sub-module encoder_input_filter (SYNC_STAGES, FILTER_LEN): one instance per channel.
//     It holds the sync chain plus the deglitch counter and outputs the filtered level.
//   - Top level: decode, position, period and error logic, all registered outputs.
// TESTING
//   1. Forward sequence x8, i_polarity=0 -> 8 o_step pulses, o_position=8, o_dir=1, o_err=0.
//      Each pulse arrives SYNC_STAGES+FILTER_LEN+1 cycles after its edge.
//   2. Forward x4 then reverse x2 -> o_position=2.
//      o_dir_change pulses once, on the first reverse step.
//      Repeat with i_polarity=1 -> o_position=-2.
//   3. Glitch of FILTER_LEN-1 cycles on A -> no step; glitch of FILTER_LEN cycles -> exactly one step.
//   4. ab 00->11 in one cycle -> o_err=1, position unchanged, next legal step counts.
//      i_clear -> o_err=0, o_position=0.
//   5. Steps spaced 100 cycles -> o_period=100 with o_period_valid.
//      Gap >2^PERIOD_WIDTH -> o_stalled=1, next o_period=2^PERIOD_WIDTH-1.
//   6. Load 2^(POS_WIDTH-1)-1, one up step -> o_position=-2^(POS_WIDTH-1).
//      i_load with a coincident step -> o_position=i_load_val.
//      i_rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/quad_encoder_counter_pkg.sv
// encoder_pkg: shared quadrature state type, forward Gray table and period saturation constant.
package encoder_pkg;

    typedef enum logic [1:0] {
        AB_00 = 2'b00,
        AB_01 = 2'b01,
        AB_10 = 2'b10,
        AB_11 = 2'b11
    } ab_t;

    // All-ones source for the period saturation value; sliced to the counter width at the top.
    localparam logic [63:0] PERIOD_SAT_ALL = '1;

    function automatic ab_t next_fwd(ab_t ab);
        return ab == AB_00 ? AB_10 :
               ab == AB_10 ? AB_11 :
               ab == AB_11 ? AB_01 : AB_00;
    endfunction

endpackage

// File: rtl/quad_encoder_counter_if.sv
// quad_encoder_counter_if: encoder inputs, control strobes and decoded outputs of the counter.
interface quad_encoder_counter_if #(
    parameter int POS_WIDTH    = 32,
    parameter int PERIOD_WIDTH = 20
);

    logic                    i_a;
    logic                    i_b;
    logic                    i_polarity;
    logic                    i_clear;
    logic                    i_load;
    logic [POS_WIDTH-1:0]    i_load_val;
    logic                    o_step;
    logic                    o_dir;
    logic                    o_dir_change;
    logic [POS_WIDTH-1:0]    o_position;
    logic [PERIOD_WIDTH-1:0] o_period;
    logic                    o_period_valid;
    logic                    o_stalled;
    logic                    o_err;

    modport master (
        output i_a, i_b, i_polarity, i_clear, i_load, i_load_val,
        input  o_step, o_dir, o_dir_change, o_position, o_period, o_period_valid, o_stalled, o_err
    );

    modport slave (
        input  i_a, i_b, i_polarity, i_clear, i_load, i_load_val,
        output o_step, o_dir, o_dir_change, o_position, o_period, o_period_valid, o_stalled, o_err
    );

endinterface

// File: rtl/quad_encoder_counter_input_filter.sv
// encoder_input_filter: synchroniser chain plus deglitch counter for one encoder channel.
module encoder_input_filter #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_level
);

    localparam int CW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt;
    logic                   r_level;
    logic                   w_synced;

    assign w_synced = r_sync[SYNC_STAGES-1];
    assign o_level  = r_level;

    // The level flips on the FILTER_LEN-th consecutive differing sample.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
            if (w_synced == r_level)
                r_cnt <= '0;
            else if (r_cnt == LAST) begin
                r_level <= w_synced;
                r_cnt   <= '0;
            end else
                r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quad_encoder_counter.sv
// quad_encoder_counter: x4 quadrature decoder with signed position, step period and error tracking.
module quad_encoder_counter
    import encoder_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int FILTER_LEN   = 4,
    parameter int POS_WIDTH    = 32,
    parameter int PERIOD_WIDTH = 20
) (
    input logic              i_clk,
    input logic              i_rst,
    quad_encoder_counter_if.slave bus
);

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_SAT = PERIOD_SAT_ALL[PERIOD_WIDTH-1:0];

    logic                    w_a;
    logic                    w_b;
    logic                    w_fwd;
    logic                    w_rev;
    logic                    w_ill;
    logic                    w_up;
    logic                    w_step;
    ab_t                     w_ab;
    ab_t                     r_prev;
    logic [PERIOD_WIDTH-1:0] w_inc;
    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [POS_WIDTH-1:0]    r_pos;
    logic                    r_step;
    logic                    r_dir;
    logic                    r_dir_change;
    logic                    r_period_valid;
    logic                    r_stalled;
    logic                    r_err;
    logic                    r_seen;

    encoder_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_in    (bus.i_a),
        .o_level (w_a)
    );

    encoder_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_in    (bus.i_b),
        .o_level (w_b)
    );

    always_comb begin
        w_ab   = ab_t'({w_a, w_b});
        w_fwd  = w_ab == next_fwd(r_prev);
        w_rev  = r_prev == next_fwd(w_ab);
        w_ill  = w_ab != r_prev && !w_fwd && !w_rev;
        w_up   = w_fwd ^ bus.i_polarity;
        w_step = (w_fwd || w_rev) && !bus.i_clear && !bus.i_load;
        w_inc  = r_cnt == PERIOD_SAT ? PERIOD_SAT : r_cnt + 1'b1;
    end

    // r_seen gates dir_change and period_valid until a first step after reset/clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev         <= AB_00;
            r_pos          <= '0;
            r_cnt          <= '0;
            r_period       <= '0;
            r_step         <= 1'b0;
            r_dir          <= 1'b0;
            r_dir_change   <= 1'b0;
            r_period_valid <= 1'b0;
            r_stalled      <= 1'b0;
            r_err          <= 1'b0;
            r_seen         <= 1'b0;
        end else begin
            r_prev         <= w_ab;
            r_step         <= w_step;
            r_dir_change   <= w_step && r_seen && (w_up != r_dir);
            r_period_valid <= w_step && r_seen;
            if (bus.i_clear) begin
                r_pos     <= '0;
                r_err     <= 1'b0;
                r_cnt     <= '0;
                r_stalled <= 1'b0;
                r_seen    <= 1'b0;
            end else begin
                if (w_ill)
                    r_err <= 1'b1;
                if (bus.i_load)
                    r_pos <= bus.i_load_val;
                else if (w_step)
                    r_pos <= w_up ? r_pos + 1'b1 : r_pos - 1'b1;
                if (w_step) begin
                    r_dir     <= w_up;
                    r_period  <= w_inc;
                    r_cnt     <= '0;
                    r_stalled <= 1'b0;
                    r_seen    <= 1'b1;
                end else begin
                    r_cnt     <= w_inc;
                    r_stalled <= w_inc == PERIOD_SAT;
                end
            end
        end
    end

    assign bus.o_step         = r_step;
    assign bus.o_dir          = r_dir;
    assign bus.o_dir_change   = r_dir_change;
    assign bus.o_position     = r_pos;
    assign bus.o_period       = r_period;
    assign bus.o_period_valid = r_period_valid;
    assign bus.o_stalled      = r_stalled;
    assign bus.o_err          = r_err;

endmodule

// File: tb/tb_quad_encoder_counter.sv
// tb_quad_encoder_counter: randomized scenario bench against a Gray-index reference model.
module tb_quad_encoder_counter;

    localparam int S    = 2;
    localparam int F    = 4;
    localparam int PW   = 32;
    localparam int PERW = 10;
    localparam int L    = S + F + 1;
    localparam logic [PERW-1:0] SAT = '1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    quad_encoder_counter_if #(.POS_WIDTH(PW), .PERIOD_WIDTH(PERW)) bus();

    quad_encoder_counter #(.SYNC_STAGES(S), .FILTER_LEN(F), .POS_WIDTH(PW), .PERIOD_WIDTH(PERW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int chg_cyc = 0;
    int last_step_cyc = 0;
    int n_step = 0;
    int n_dc = 0;
    int n_pv = 0;
    logic [PERW-1:0] last_period = '0;

    // Reference model: position of the encoder on the Gray cycle plus expected counters.
    logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    int gi = 0;
    bit pol = 1'b0;
    bit m_seen = 1'b0;
    bit m_dir = 1'b0;
    logic [PW-1:0] m_pos = '0;
    int exp_step = 0;
    int exp_dc = 0;
    int exp_pv = 0;
    int m_last_chg = 0;
    logic [PERW-1:0] exp_period = '0;

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (bus.o_step) begin
            n_step++;
            last_step_cyc = cyc;
        end
        if (bus.o_dir_change) n_dc++;
        if (bus.o_period_valid) begin
            n_pv++;
            last_period = bus.o_period;
        end
    end

    task automatic model_step(input bit fwd);
        bit up;
        int d;
        up = fwd ^ pol;
        d  = cyc - m_last_chg;
        if (m_seen) begin
            if (up != m_dir) exp_dc++;
            exp_pv++;
            exp_period = d >= int'(SAT) ? SAT : PERW'(d);
        end
        m_seen = 1'b1;
        m_dir  = up;
        m_pos  = up ? m_pos + 1 : m_pos - 1;
        exp_step++;
        m_last_chg = cyc;
    endtask

    task automatic move(input bit fwd, input int hold);
        @(negedge clk);
        gi = (gi + (fwd ? 1 : 3)) % 4;
        {bus.i_a, bus.i_b} = gray[gi];
        chg_cyc = cyc;
        model_step(fwd);
        repeat (hold - 1) @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pol(input bit p);
        pol = p;
        bus.i_polarity = p;
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
        m_pos  = '0;
        m_seen = 1'b0;
    endtask

    task automatic test_reset();
        idle(3);
        checks++;
        if ({bus.o_step, bus.o_dir, bus.o_dir_change, bus.o_period_valid, bus.o_stalled, bus.o_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 000000", {bus.o_step, bus.o_dir, bus.o_dir_change, bus.o_period_valid, bus.o_stalled, bus.o_err});
        end
        checks++;
        if (bus.o_position !== '0 || bus.o_period !== '0) begin
            errors++;
            $display("FAIL reset_values: position %0h period %0h want 0 0", bus.o_position, bus.o_period);
        end
        rst = 1'b0;
        idle(15);
        checks++;
        if (n_step !== 0 || bus.o_position !== '0 || bus.o_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: steps %0d position %0h err %b want 0 0 0", n_step, bus.o_position, bus.o_err);
        end
    endtask

    task automatic test_forward();
        set_pol(1'b0);
        for (int i = 0; i < 8; i++) begin
            move(1'b1, 12);
            checks++;
            if (last_step_cyc - chg_cyc !== L) begin
                errors++;
                $display("FAIL fwd_latency[%0d]: got %0d want %0d", i, last_step_cyc - chg_cyc, L);
            end
        end
        checks++;
        if (bus.o_position !== PW'(8) || n_step !== 8) begin
            errors++;
            $display("FAIL fwd_position: got %0d steps %0d want 8 steps 8", $signed(bus.o_position), n_step);
        end
        checks++;
        if (bus.o_dir !== 1'b1 || bus.o_err !== 1'b0) begin
            errors++;
            $display("FAIL fwd_dir_err: dir %b err %b want 1 0", bus.o_dir, bus.o_err);
        end
    endtask

    task automatic test_reverse();
        logic [PW-1:0] want;
        int dc0;
        for (int p = 0; p < 2; p++) begin
            set_pol(p[0]);
            do_clear();
            dc0 = n_dc;
            for (int i = 0; i < 4; i++) move(1'b1, 12);
            for (int i = 0; i < 2; i++) move(1'b0, 12);
            want = p[0] ? -PW'(2) : PW'(2);
            checks++;
            if (bus.o_position !== want) begin
                errors++;
                $display("FAIL rev_position[pol=%0d]: got %0d want %0d", p, $signed(bus.o_position), $signed(want));
            end
            checks++;
            if (n_dc - dc0 !== 1) begin
                errors++;
                $display("FAIL rev_dir_change[pol=%0d]: got %0d pulses want 1", p, n_dc - dc0);
            end
        end
    endtask

    task automatic test_glitch();
        int gn;
        int old;
        bit fwd;
        logic [PW-1:0] mid_pos;
        int mid_step;
        set_pol(1'b0);
        @(negedge clk);
        bus.i_a = ~bus.i_a;
        repeat (F - 1) @(negedge clk);
        bus.i_a = ~bus.i_a;
        idle(20);
        checks++;
        if (n_step !== exp_step || bus.o_position !== m_pos) begin
            errors++;
            $display("FAIL glitch_short: steps %0d pos %0d want %0d %0d", n_step, $signed(bus.o_position), exp_step, $signed(m_pos));
        end
        gn = 0;
        for (int k = 0; k < 4; k++) if (gray[k] == {~bus.i_a, bus.i_b}) gn = k;
        fwd = ((gn - gi + 4) % 4) == 1;
        old = gi;
        @(negedge clk);
        bus.i_a = ~bus.i_a;
        gi = gn;
        model_step(fwd);
        mid_pos  = m_pos;
        mid_step = exp_step;
        repeat (F) @(negedge clk);
        bus.i_a = ~bus.i_a;
        gi = old;
        model_step(!fwd);
        idle(L - 1);
        checks++;
        if (n_step !== mid_step || bus.o_position !== mid_pos) begin
            errors++;
            $display("FAIL glitch_full: steps %0d pos %0d want %0d %0d", n_step, $signed(bus.o_position), mid_step, $signed(mid_pos));
        end
        idle(15);
        checks++;
        if (n_step !== exp_step || bus.o_position !== m_pos) begin
            errors++;
            $display("FAIL glitch_return: steps %0d pos %0d want %0d %0d", n_step, $signed(bus.o_position), exp_step, $signed(m_pos));
        end
    endtask

    task automatic test_illegal();
        int pv0;
        int dc0;
        @(negedge clk);
        gi = (gi + 2) % 4;
        {bus.i_a, bus.i_b} = gray[gi];
        idle(15);
        checks++;
        if (bus.o_err !== 1'b1 || bus.o_position !== m_pos || n_step !== exp_step) begin
            errors++;
            $display("FAIL illegal: err %b pos %0d steps %0d want 1 %0d %0d", bus.o_err, $signed(bus.o_position), n_step, $signed(m_pos), exp_step);
        end
        move(1'b1, 12);
        checks++;
        if (bus.o_position !== m_pos || n_step !== exp_step) begin
            errors++;
            $display("FAIL illegal_resync: pos %0d steps %0d want %0d %0d", $signed(bus.o_position), n_step, $signed(m_pos), exp_step);
        end
        do_clear();
        idle(2);
        checks++;
        if (bus.o_err !== 1'b0 || bus.o_position !== '0) begin
            errors++;
            $display("FAIL clear: err %b pos %0d want 0 0", bus.o_err, $signed(bus.o_position));
        end
        pv0 = n_pv;
        dc0 = n_dc;
        move(1'b0, 12);
        checks++;
        if (n_pv !== pv0 || n_dc !== dc0 || bus.o_position !== m_pos) begin
            errors++;
            $display("FAIL clear_first_step: pv %0d dc %0d pos %0d want %0d %0d %0d", n_pv, n_dc, $signed(bus.o_position), pv0, dc0, $signed(m_pos));
        end
    endtask

    task automatic test_period();
        int g;
        for (int i = 0; i < 3; i++) move(1'b1, 100);
        checks++;
        if (last_period !== PERW'(100) || n_pv !== exp_pv) begin
            errors++;
            $display("FAIL period_100: got %0d pulses %0d want 100 %0d", last_period, n_pv, exp_pv);
        end
        for (int i = 0; i < 4; i++) begin
            g = $urandom_range(20, 300);
            move(1'($urandom_range(0, 1)), g);
            checks++;
            if (last_period !== exp_period || n_pv !== exp_pv || bus.o_stalled !== 1'b0) begin
                errors++;
                $display("FAIL period_rand[%0d]: got %0d pulses %0d stalled %b want %0d %0d 0", i, last_period, n_pv, bus.o_stalled, exp_period, exp_pv);
            end
        end
        move(1'b1, 1100);
        checks++;
        if (bus.o_stalled !== 1'b1) begin
            errors++;
            $display("FAIL stalled: got %b want 1", bus.o_stalled);
        end
        move(1'b1, 20);
        checks++;
        if (last_period !== SAT || exp_period !== SAT || bus.o_stalled !== 1'b0) begin
            errors++;
            $display("FAIL stall_period: got %0d stalled %b want %0d 0", last_period, bus.o_stalled, SAT);
        end
    endtask

    task automatic test_random();
        set_pol(1'($urandom_range(0, 1)));
        for (int i = 0; i < 40; i++) move(1'($urandom_range(0, 1)), $urandom_range(10, 40));
        checks++;
        if (bus.o_position !== m_pos || n_step !== exp_step) begin
            errors++;
            $display("FAIL rand_position: pos %0d steps %0d want %0d %0d", $signed(bus.o_position), n_step, $signed(m_pos), exp_step);
        end
        checks++;
        if (n_dc !== exp_dc || bus.o_dir !== m_dir) begin
            errors++;
            $display("FAIL rand_dir: dc %0d dir %b want %0d %b", n_dc, bus.o_dir, exp_dc, m_dir);
        end
        checks++;
        if (n_pv !== exp_pv || last_period !== exp_period) begin
            errors++;
            $display("FAIL rand_period: pv %0d period %0d want %0d %0d", n_pv, last_period, exp_pv, exp_period);
        end
    endtask

    task automatic test_load();
        logic [PW-1:0] v;
        set_pol(1'b0);
        @(negedge clk);
        bus.i_load = 1'b1;
        bus.i_load_val = 32'h7FFF_FFFF;
        @(negedge clk);
        bus.i_load = 1'b0;
        m_pos = 32'h7FFF_FFFF;
        move(1'b1, 12);
        checks++;
        if (bus.o_position !== 32'h8000_0000 || m_pos !== 32'h8000_0000) begin
            errors++;
            $display("FAIL load_wrap: got %0h want 80000000", bus.o_position);
        end
        v = $urandom;
        @(negedge clk);
        gi = (gi + 1) % 4;
        {bus.i_a, bus.i_b} = gray[gi];
        repeat (L - 1) @(negedge clk);
        bus.i_load = 1'b1;
        bus.i_load_val = v;
        @(negedge clk);
        bus.i_load = 1'b0;
        m_pos = v;
        idle(10);
        checks++;
        if (bus.o_position !== v || n_step !== exp_step) begin
            errors++;
            $display("FAIL load_step: pos %0h steps %0d want %0h %0d", bus.o_position, n_step, v, exp_step);
        end
    endtask

    task automatic test_midreset();
        int s0;
        int pv0;
        @(negedge clk);
        bus.i_b = ~bus.i_b;
        idle(3);
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.o_step, bus.o_dir, bus.o_dir_change, bus.o_period_valid, bus.o_stalled, bus.o_err} !== 6'b0 ||
            bus.o_position !== '0 || bus.o_period !== '0) begin
            errors++;
            $display("FAIL midreset: flags %b pos %0h period %0h want 0", {bus.o_step, bus.o_dir, bus.o_dir_change, bus.o_period_valid, bus.o_stalled, bus.o_err}, bus.o_position, bus.o_period);
        end
        {bus.i_a, bus.i_b} = 2'b00;
        gi = 0;
        idle(3);
        rst = 1'b0;
        m_pos  = '0;
        m_seen = 1'b0;
        m_dir  = 1'b0;
        s0  = n_step;
        pv0 = n_pv;
        idle(20);
        checks++;
        if (n_step !== s0 || bus.o_position !== '0 || bus.o_err !== 1'b0 || bus.o_dir !== 1'b0) begin
            errors++;
            $display("FAIL midreset_release: steps %0d pos %0h err %b dir %b want %0d 0 0 0", n_step, bus.o_position, bus.o_err, bus.o_dir, s0);
        end
        move(1'b1, 12);
        checks++;
        if (bus.o_position !== PW'(1) || n_pv !== pv0) begin
            errors++;
            $display("FAIL midreset_step: pos %0d pv %0d want 1 %0d", $signed(bus.o_position), n_pv, pv0);
        end
    endtask

    initial begin
        bus.i_a = 1'b0;
        bus.i_b = 1'b0;
        bus.i_polarity = 1'b0;
        bus.i_clear = 1'b0;
        bus.i_load = 1'b0;
        bus.i_load_val = '0;
        test_reset();
        test_forward();
        test_reverse();
        test_glitch();
        test_illegal();
        test_period();
        test_random();
        test_load();
        test_midreset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
